// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_switch_ctrl
// Description : Sequencing controller for the glitch-free clock multiplexer.
//               Accepts source-change requests over a valid/ready handshake,
//               drives the mux select, holds off changes for a settle window
//               and fails over to the lowest-index healthy source when the
//               active source is flagged as failed.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_switch_ctrl #(
    parameter int CLK_NUM    = 4,
    parameter int SETTLE_CYC = 16,
    parameter int DEF_SEL    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CLK_NUM-1:0]         clk_fail,
    input  logic                       req_vld,
    input  logic [$clog2(CLK_NUM)-1:0] req_sel,
    output logic                       req_rdy,
    output logic                       req_err,
    output logic [$clog2(CLK_NUM)-1:0] sel,
    output logic                       busy,
    output logic                       done,
    output logic                       failover,
    output logic                       all_fail
);

    localparam int SW    = $clog2(CLK_NUM);
    localparam int CW    = $clog2(SETTLE_CYC + 1);
    localparam int c_PAD = 2 ** SW;

    localparam logic [CW-1:0] c_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] c_DEF  = SW'(DEF_SEL);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_SETTLE = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [SW-1:0]    r_sel;
    logic [SW-1:0]    w_sel_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_fo;
    logic             w_fo_nxt;

    logic [c_PAD-1:0] w_fail_pad;
    logic [SW-1:0]    w_fb;
    logic             w_all_fail;
    logic             w_sel_fail;
    logic             w_req_bad;
    logic             w_rdy;

    // Indices beyond CLK_NUM are treated as permanently failed, so an
    // out-of-range request is rejected by the same test as a failed source.
    if (c_PAD > CLK_NUM) begin : g_pad
        assign w_fail_pad = {{(c_PAD - CLK_NUM){1'b1}}, clk_fail};
    end else begin : g_nopad
        assign w_fail_pad = clk_fail;
    end

    assign w_all_fail = &clk_fail;
    assign w_sel_fail = w_fail_pad[r_sel];
    assign w_req_bad  = w_fail_pad[req_sel];
    assign w_rdy      = (r_state == c_ST_IDLE) && !w_sel_fail;

    // Fallback target: lowest-index source whose fail flag is clear.
    always_comb begin
        w_fb = '0;
        for (int i = CLK_NUM - 1; i >= 0; i--) begin
            if (!clk_fail[i]) begin
                w_fb = SW'(i);
            end
        end
    end

    // Next-state and registered-output decode; failover outranks requests.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_fo_nxt    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_sel_fail) begin
                    // With every source failed there is nowhere to go; wait
                    // in IDLE until some flag clears.
                    if (!w_all_fail) begin
                        w_sel_nxt   = w_fb;
                        w_cnt_nxt   = c_LOAD;
                        w_fo_nxt    = 1'b1;
                        w_state_nxt = c_ST_SETTLE;
                    end
                end else if (req_vld) begin
                    if (w_req_bad) begin
                        w_err_nxt = 1'b1;
                    end else if (req_sel == r_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_sel_nxt   = req_sel;
                        w_cnt_nxt   = c_LOAD;
                        w_state_nxt = c_ST_SETTLE;
                    end
                end
            end
            c_ST_SETTLE: begin
                if (w_sel_fail) begin
                    // Abort the switch in progress; no done for it.
                    if (!w_all_fail) begin
                        w_sel_nxt = w_fb;
                        w_cnt_nxt = c_LOAD;
                        w_fo_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (r_cnt == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, select, settle counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_sel   <= c_DEF;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_fo    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_fo    <= w_fo_nxt;
        end
    end

    assign req_rdy  = w_rdy;
    assign req_err  = r_err;
    assign sel      = r_sel;
    assign busy     = (r_state == c_ST_SETTLE);
    assign done     = r_done;
    assign failover = r_fo;
    assign all_fail = w_all_fail;

endmodule
`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_switch_ctrl
// Description : Self-checking bench for clk_switch_ctrl: a vector table, hand
//               sequences for multi-cycle corners, and random stimulus checked
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_switch_ctrl;

    localparam int N = 4;
    localparam int S = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] clk_fail;
    logic       req_vld;
    logic [1:0] req_sel;
    logic       req_rdy, req_err, busy, done, failover, all_fail;
    logic [1:0] sel;

    // Second instance with a non-power-of-two source count.
    logic [2:0] b_fail;
    logic       b_vld;
    logic [1:0] b_rsel;
    logic       b_rdy, b_err, b_busy, b_done, b_fo, b_all;
    logic [1:0] b_sel;

    int errors = 0;
    int checks = 0;

    // Behavioural model: current select, busy cycles remaining, pulses.
    int   m_sel, m_left;
    bit   m_done, m_err, m_fo;
    logic [3:0] cur_f;
    logic       cur_v;
    logic [1:0] cur_rs;

    typedef struct packed {
        logic [3:0] f;
        logic       v;
        logic [1:0] rs;
        logic [1:0] e_sel;
        logic       e_busy, e_done, e_err, e_fo, e_rdy;
    } vec_t;
    vec_t tbl [0:21];

    clk_switch_ctrl #(.CLK_NUM(N), .SETTLE_CYC(S), .DEF_SEL(0)) dut (
        .clk(clk), .rst_n(rst_n), .clk_fail(clk_fail), .req_vld(req_vld),
        .req_sel(req_sel), .req_rdy(req_rdy), .req_err(req_err), .sel(sel),
        .busy(busy), .done(done), .failover(failover), .all_fail(all_fail)
    );

    clk_switch_ctrl #(.CLK_NUM(3), .SETTLE_CYC(2), .DEF_SEL(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_fail(b_fail), .req_vld(b_vld),
        .req_sel(b_rsel), .req_rdy(b_rdy), .req_err(b_err), .sel(b_sel),
        .busy(b_busy), .done(b_done), .failover(b_fo), .all_fail(b_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int first_ok(input logic [3:0] f);
        for (int i = N - 1; i >= 0; i--) if (!f[i]) first_ok = i;
        if (&f) first_ok = m_sel;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_left = 0; m_done = 0; m_err = 0; m_fo = 0;
    endtask

    // Advance the model by one clock using the inputs held across the edge.
    task automatic model_step();
        bit sel_failed;
        sel_failed = cur_f[m_sel];
        m_done = 0; m_err = 0; m_fo = 0;
        if (sel_failed) begin
            if (!(&cur_f)) begin
                m_sel = first_ok(cur_f); m_left = S; m_fo = 1;
            end else begin
                m_left = 0;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (cur_v) begin
            if (int'(cur_rs) >= N || cur_f[cur_rs]) m_err = 1;
            else if (int'(cur_rs) == m_sel) m_done = 1;
            else begin m_sel = cur_rs; m_left = S; end
        end
    endtask

    task automatic check_model();
        chk("m.sel", 32'(sel), 32'(m_sel));
        chk("m.busy", 32'(busy), 32'(m_left > 0));
        chk("m.done", 32'(done), 32'(m_done));
        chk("m.err", 32'(req_err), 32'(m_err));
        chk("m.failover", 32'(failover), 32'(m_fo));
        chk("m.all_fail", 32'(all_fail), 32'(&cur_f));
        chk("m.rdy", 32'(req_rdy), 32'((m_left == 0) && !cur_f[m_sel]));
    endtask

    task automatic apply(input logic [3:0] f, input logic v, input logic [1:0] rs);
        @(negedge clk);
        clk_fail = f; req_vld = v; req_sel = rs;
        cur_f = f; cur_v = v; cur_rs = rs;
        #1;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
    endtask

    task automatic step(input logic [3:0] f, input logic v, input logic [1:0] rs);
        apply(f, v, rs);
        advance();
    endtask

    task automatic add(input int i, input logic [3:0] f, input logic v, input logic [1:0] rs,
                       input logic [1:0] es, input logic eb, input logic ed, input logic ee,
                       input logic ef, input logic er);
        tbl[i] = {f, v, rs, es, eb, ed, ee, ef, er};
    endtask

    initial begin
        int done_cnt, done_at, fo_at;
        logic [3:0] rf;

        // f, v, rs | sel busy done err fo rdy
        add( 0, 4'h0, 1, 2,  0, 0, 0, 0, 0, 1);
        add( 1, 4'h0, 0, 0,  2, 1, 0, 0, 0, 0);
        add( 2, 4'h0, 0, 0,  2, 1, 0, 0, 0, 0);
        add( 3, 4'h0, 0, 0,  2, 1, 0, 0, 0, 0);
        add( 4, 4'h0, 0, 0,  2, 1, 0, 0, 0, 0);
        add( 5, 4'h0, 0, 0,  2, 0, 1, 0, 0, 1);
        add( 6, 4'h8, 1, 3,  2, 0, 0, 0, 0, 1);
        add( 7, 4'h8, 0, 0,  2, 0, 0, 1, 0, 1);
        add( 8, 4'h0, 1, 2,  2, 0, 0, 0, 0, 1);
        add( 9, 4'h0, 0, 0,  2, 0, 1, 0, 0, 1);
        add(10, 4'h0, 1, 0,  2, 0, 0, 0, 0, 1);
        add(11, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(12, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(13, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(14, 4'h0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(15, 4'h0, 0, 0,  0, 0, 1, 0, 0, 1);
        add(16, 4'h3, 1, 1,  0, 0, 0, 0, 0, 0);
        add(17, 4'h3, 0, 0,  2, 1, 0, 0, 1, 0);
        add(18, 4'h3, 0, 0,  2, 1, 0, 0, 0, 0);
        add(19, 4'h3, 0, 0,  2, 1, 0, 0, 0, 0);
        add(20, 4'h3, 0, 0,  2, 1, 0, 0, 0, 0);
        add(21, 4'h3, 0, 0,  2, 0, 1, 0, 0, 1);

        rst_n = 1'b0; clk_fail = '0; req_vld = 1'b0; req_sel = '0;
        b_fail = '0; b_vld = 1'b0; b_rsel = '0;
        cur_f = '0; cur_v = 1'b0; cur_rs = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.sel", 32'(sel), 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.pulses", 32'({done, req_err, failover}), 0);
        rst_n = 1'b1;

        // Vector table: normal switch, rejected request, same-source request,
        // failover from IDLE with a simultaneous request.
        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].f, tbl[i].v, tbl[i].rs);
            chk($sformatf("tbl%0d.sel", i), 32'(sel), 32'(tbl[i].e_sel));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d.err", i), 32'(req_err), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d.fo", i), 32'(failover), 32'(tbl[i].e_fo));
            chk($sformatf("tbl%0d.rdy", i), 32'(req_rdy), 32'(tbl[i].e_rdy));
            advance();
        end

        // Failover during SETTLE: switch to 1, fail it on busy cycle 2.
        step(4'h0, 1, 1);
        step(4'h0, 0, 0);
        step(4'h2, 0, 0);
        done_cnt = 0; done_at = -1; fo_at = -1;
        for (int k = 0; k < 7; k++) begin
            apply(4'h2, 0, 0);
            if (done) begin done_cnt++; done_at = k; end
            if (failover && fo_at < 0) fo_at = k;
            if (k == 0) chk("settle_fo.sel", 32'(sel), 0);
            advance();
        end
        chk("settle_fo.fo_at", 32'(fo_at), 0);
        chk("settle_fo.done_at", 32'(done_at), 4);
        chk("settle_fo.done_cnt", 32'(done_cnt), 1);

        // All sources failed: hold, then recover to source 3.
        for (int k = 0; k < 3; k++) begin
            apply(4'hF, 1, 1);
            chk("allfail.flag", 32'(all_fail), 1);
            chk("allfail.rdy", 32'(req_rdy), 0);
            chk("allfail.sel", 32'(sel), 0);
            advance();
        end
        step(4'h7, 0, 0);
        apply(4'h7, 0, 0);
        chk("recover.sel", 32'(sel), 3);
        chk("recover.fo", 32'(failover), 1);
        advance();
        for (int k = 0; k < 5; k++) step(4'h7, 0, 0);

        // Request and fail together: failover wins, then async reset mid-SETTLE.
        step(4'h0, 0, 0);
        apply(4'h8, 1, 2);
        chk("race.rdy", 32'(req_rdy), 0);
        advance();
        apply(4'h9, 0, 0);
        advance();
        apply(4'h9, 0, 0);
        chk("race.sel", 32'(sel), 1);
        advance();
        apply(4'h0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("areset.sel", 32'(sel), 0);
        chk("areset.busy", 32'(busy), 0);
        chk("areset.fo", 32'(failover), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-source instance: index 3 does not exist.
        @(negedge clk);
        b_vld = 1'b1; b_rsel = 2'd3;
        #1;
        chk("n3.rdy", 32'(b_rdy), 1);
        @(negedge clk);
        b_vld = 1'b0;
        #1;
        chk("n3.err", 32'(b_err), 1);
        chk("n3.sel", 32'(b_sel), 0);
        chk("n3.busy", 32'(b_busy), 0);
        @(negedge clk);
        chk("n3.err_once", 32'(b_err), 0);

        // Random traffic against the model.
        rf = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                rf = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            end
            step(rf, 1'($urandom), 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
